// File: rtl/popcount_stream.sv
// rtl/popcount_stream.sv - per-packet ones/zeros counter on a valid/ready stream
//
// Counts set bits (mode=0) or clear bits (mode=1) in every accepted WIDTH-bit
// word and accumulates them, with saturation, over a packet. The packet total,
// beat count and saturation flag are presented on a held output handshake.
// Only one packet is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = count ones, 1 = count zeros (taken from the first beat)
//   in_valid   input beat valid
//   in_ready   block can accept a beat (high in ACCUM)
//   in_data    input word
//   in_last    final beat of packet
//   out_valid  result valid (high in HOLD)
//   out_ready  consumer accepts result
//   out_count  packet total, saturating at 2^ACC_W-1
//   out_words  beats in packet, saturating at 2^WCNT_W-1
//   out_sat    accumulator saturated during the packet
module popcount_stream #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 16,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic [WCNT_W-1:0] out_words,
  output logic              out_sat
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] WIDTH_P = PW'(WIDTH);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0]  acc;
  logic [WCNT_W-1:0] words;
  logic              sat;
  logic              first;
  logic              mode_lat;

  logic [PW-1:0]     ones;
  logic [PW-1:0]     pop;
  logic              mode_eff;
  logic              accept;
  logic [ACC_W:0]    sum;
  logic              ovf;
  logic [ACC_W-1:0]  acc_nxt;
  logic [WCNT_W-1:0] words_nxt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && in_last) state_nxt = HOLD;
      HOLD:  if (out_ready)         state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output logic: the handshake signals are a pure decode of the state, so
  // in_ready only returns the cycle after the result is taken.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: in_ready  = 1'b1;
      HOLD:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // The live mode input only matters on the first beat; later beats use the
  // value captured then, so a packet is counted consistently.
  assign mode_eff = first ? mode : mode_lat;

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + PW'(in_data[i]);
    end
  end

  assign pop = mode_eff ? (WIDTH_P - ones) : ones;

  // One extra bit catches the carry; the result clamps instead of wrapping.
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(pop);
  assign ovf     = sum[ACC_W];
  assign acc_nxt = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

  assign words_nxt = (words == {WCNT_W{1'b1}}) ? words : words + 1'b1;

  // Datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      words     <= '0;
      sat       <= 1'b0;
      first     <= 1'b1;
      mode_lat  <= 1'b0;
      out_count <= '0;
      out_words <= '0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      if (first) begin
        mode_lat <= mode;
      end
      if (in_last) begin
        out_count <= acc_nxt;
        out_words <= words_nxt;
        out_sat   <= sat | ovf;
        acc       <= '0;
        words     <= '0;
        sat       <= 1'b0;
        first     <= 1'b1;
      end else begin
        acc   <= acc_nxt;
        words <= words_nxt;
        sat   <= sat | ovf;
        first <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_popcount_stream.sv
// tb/tb_popcount_stream.sv - scoreboard bench for popcount_stream
module tb_popcount_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_count;
  logic [7:0]  out_words;

  logic        in_ready_s, out_valid_s, out_sat_s;
  logic [4:0]  out_count_s;
  logic [7:0]  out_words_s;

  int total = 0;
  int bad = 0;

  typedef struct {
    int count;
    int count_s;
    int words;
    int sat;
    int sat_s;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  popcount_stream dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_words(out_words), .out_sat(out_sat)
  );

  popcount_stream #(.WIDTH(8), .ACC_W(5), .WCNT_W(8)) dut_s (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_count(out_count_s),
    .out_words(out_words_s), .out_sat(out_sat_s)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_pkt(input int c, input int cs, input int w, input int s, input int ss);
    exp_t e;
    e.count = c; e.count_s = cs; e.words = w; e.sat = s; e.sat_s = ss;
    sb.push_back(e);
  endtask

  // Monitor: compares each result handshake against the oldest expectation.
  always @(negedge clk) begin
    if ((out_valid || out_valid_s) && out_ready) begin
      check("valid_agree", int'(out_valid_s), int'(out_valid));
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got count=%0d with empty scoreboard", out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_count", int'(out_count), e.count);
        check("out_words", int'(out_words), e.words);
        check("out_sat", int'(out_sat), e.sat);
        check("out_count_acc5", int'(out_count_s), e.count_s);
        check("out_words_acc5", int'(out_words_s), e.words);
        check("out_sat_acc5", int'(out_sat_s), e.sat_s);
      end
    end
  end

  // Drives one beat and returns just after the edge that accepted it.
  task automatic beat(input logic [7:0] d, input logic last, input logic m);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: in_ready=%0d expected 1", in_ready);
    end
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int guard;
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_words", int'(out_words), 0);
    check("rst_out_sat", int'(out_sat), 0);
    @(posedge clk); #2;
    reset = 1'b0;
    idle(1);

    // Single beat, result held until out_ready.
    out_ready = 1'b0;
    expect_pkt(5, 5, 1, 0, 0);
    beat(8'b1010_0111, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("t1_out_valid", int'(out_valid), 1);
    check("t1_in_ready", int'(in_ready), 0);
    @(posedge clk); #2;
    check("t1_in_ready_hold", int'(in_ready), 0);
    check("t1_out_valid_hold", int'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("t1_out_valid_after", int'(out_valid), 0);
    check("t1_in_ready_after", int'(in_ready), 1);

    // Three back-to-back beats: 8 + 0 + 4.
    expect_pkt(12, 12, 3, 0, 0);
    beat(8'hFF, 1'b0, 1'b0);
    beat(8'h00, 1'b0, 1'b0);
    beat(8'b0110_1100, 1'b1, 1'b0);
    idle(2);

    // Mode latched on the first beat: zeros of 00 (8) + zeros of E0 (5).
    expect_pkt(13, 13, 2, 0, 0);
    beat(8'h00, 1'b0, 1'b1);
    beat(8'hE0, 1'b1, 1'b0);
    idle(2);

    // Saturation in the 5-bit instance; the 16-bit one reaches 40.
    expect_pkt(40, 31, 5, 0, 1);
    for (int i = 0; i < 5; i++) beat(8'hFF, (i == 4), 1'b0);
    idle(2);
    expect_pkt(1, 1, 1, 0, 0);
    beat(8'h01, 1'b1, 1'b0);
    idle(2);

    // Backpressure: result held, beats offered during HOLD are ignored.
    out_ready = 1'b0;
    expect_pkt(4, 4, 1, 0, 0);
    beat(8'h3C, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_count", int'(out_count), 4);
      check("bp_out_words", int'(out_words), 1);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("bp_in_ready_after", int'(in_ready), 1);
    check("bp_out_valid_after", int'(out_valid), 0);
    check("bp_count_kept", int'(out_count), 4);
    expect_pkt(2, 2, 1, 0, 0);
    beat(8'h81, 1'b1, 1'b0);
    idle(2);

    // Reset abort after two beats; nothing is emitted for that packet.
    beat(8'hFF, 1'b0, 1'b1);
    beat(8'hFF, 1'b0, 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_count", int'(out_count), 0);
    check("abort_out_words", int'(out_words), 0);
    check("abort_out_sat_acc5", int'(out_sat_s), 0);
    reset = 1'b0;
    @(posedge clk); #2;
    expect_pkt(4, 4, 1, 0, 0);
    beat(8'h0F, 1'b1, 1'b0);
    idle(1);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
